// File: rtl/uart_pkg.sv
// Shared types and line levels for the UART transmit path.
package uart_pkg;

    // Transmitter frame phases.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int   DATA_BITS = 8;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;
    localparam logic IDLE_LVL  = 1'b1;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Byte-wide valid/ready handshake feeding the UART transmit FIFO.
interface uart_tx_fifo_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 ready;

    // Producer side drives data/valid and watches ready.
    modport master (output data, output valid, input ready);
    // Transmitter side consumes data/valid and reports ready.
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with the head word visible combinationally.
// Pushes into a full FIFO and pops from an empty FIFO are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == FULL_COUNT);
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign head    = mem[rd_ptr_reg];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage write; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end
endmodule

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter with a small input FIFO and host flow control.
// Frames are start bit, eight data bits LSB first, one stop bit; the next
// queued byte starts straight out of the stop bit with no idle gap.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 100,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic            clk,
    input  logic            rst,
    uart_tx_fifo_if.slave   src,
    input  logic            block,
    output logic            busy,
    output logic            tx
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);
    localparam int CNTW = $clog2(FIFO_DEPTH) + 1;

    tx_state_t            state_reg;
    logic [CW-1:0]        baud_reg;
    logic [2:0]           bit_idx_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 tx_reg;

    logic [DATA_BITS-1:0] fifo_head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CNTW-1:0]      fifo_count;
    logic                 baud_last;
    logic                 pop;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (src.valid),
        .push_data (src.data),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign src.ready = !fifo_full;
    assign busy      = (state_reg != IDLE) || (fifo_count != '0);
    assign tx        = tx_reg;
    assign baud_last = (baud_reg == BAUD_LAST);

    // A new frame may only begin from idle or at the very end of a stop bit,
    // so block never cuts into a frame already on the line.
    always_comb begin
        pop = 1'b0;
        if (!fifo_empty && !block) begin
            if (state_reg == IDLE) begin
                pop = 1'b1;
            end else if (state_reg == STOP && baud_last) begin
                pop = 1'b1;
            end
        end
    end

    // Frame sequencer: baud timing, bit shifting and the registered line.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            baud_reg    <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            tx_reg      <= IDLE_LVL;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    tx_reg   <= IDLE_LVL;
                    baud_reg <= '0;
                    if (pop) begin
                        shift_reg <= fifo_head;
                        tx_reg    <= START_LVL;
                        state_reg <= START;
                    end
                end
                START: begin
                    if (baud_last) begin
                        baud_reg    <= '0;
                        bit_idx_reg <= '0;
                        tx_reg      <= shift_reg[0];
                        state_reg   <= DATA;
                    end else begin
                        baud_reg <= baud_reg + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_last) begin
                        baud_reg <= '0;
                        if (bit_idx_reg == BIT_LAST) begin
                            tx_reg    <= STOP_LVL;
                            state_reg <= STOP;
                        end else begin
                            shift_reg   <= shift_reg >> 1;
                            tx_reg      <= shift_reg[1];
                            bit_idx_reg <= bit_idx_reg + 1'b1;
                        end
                    end else begin
                        baud_reg <= baud_reg + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_last) begin
                        baud_reg <= '0;
                        if (pop) begin
                            shift_reg <= fifo_head;
                            tx_reg    <= START_LVL;
                            state_reg <= START;
                        end else begin
                            tx_reg    <= IDLE_LVL;
                            state_reg <= IDLE;
                        end
                    end else begin
                        baud_reg <= baud_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    tx_reg    <= IDLE_LVL;
                    baud_reg  <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed scenarios plus a random push phase.
// A line monitor decodes every frame seen on tx (start cycle, byte, framing
// and per-bit stability); the expected list is built from accepted bytes and
// the rule "a frame starts one cycle after acceptance, but never before the
// previous frame has finished".
module tb_uart_tx_fifo;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    typedef struct {
        logic [7:0] data;
        int         start;
        bit         ok;
    } frame_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic block = 1'b0;
    logic busy;
    logic tx;

    uart_tx_fifo_if bus ();

    uart_tx_fifo #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .src   (bus),
        .block (block),
        .busy  (busy),
        .tx    (tx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int     n_cmp = 0;
    int     n_bad = 0;
    frame_t got_q[$];
    frame_t exp_q[$];
    int     acc_q[$];
    int     last_start = -1000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int next_start(input int acc);
        int s;
        s = acc + 1;
        if (last_start + FRAME > s) s = last_start + FRAME;
        last_start = s;
        return s;
    endfunction

    task automatic exp_add(input logic [7:0] b, input int s);
        frame_t f;
        f.data  = b;
        f.start = s;
        f.ok    = 1'b1;
        exp_q.push_back(f);
    endtask

    function automatic int model_occ(input int c);
        int occ;
        occ = 0;
        foreach (acc_q[i]) if (acc_q[i] <= c) occ++;
        foreach (exp_q[i]) if (exp_q[i].start <= c) occ--;
        return occ;
    endfunction

    task automatic wait_idle(input string tag, input int limit);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < limit) begin
            tick();
            n++;
        end
        check({tag, "_idle"}, busy, 0);
        tick();
        tick();
    endtask

    task automatic check_frames(input string tag);
        int n;
        check({tag, "_nframes"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            $display("frame %s[%0d]: byte %02h start %0d ok %0d (want %02h @ %0d)",
                     tag, i, got_q[i].data, got_q[i].start, got_q[i].ok,
                     exp_q[i].data, exp_q[i].start);
            check($sformatf("%s_data%0d", tag, i), got_q[i].data, exp_q[i].data);
            check($sformatf("%s_start%0d", tag, i), got_q[i].start, exp_q[i].start);
            check($sformatf("%s_framing%0d", tag, i), got_q[i].ok, 1);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    // Line monitor: samples tx every cycle and decodes 40-cycle frames.
    initial begin : monitor
        logic [FRAME-1:0] samp;
        int               ns;
        bit               in_frame;
        int               fstart;
        frame_t           f;
        samp = '0;
        ns = 0;
        in_frame = 1'b0;
        fstart = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_frame = 1'b0;
            end else if (!in_frame) begin
                if (tx === 1'b0) begin
                    in_frame = 1'b1;
                    fstart = cyc;
                    samp[0] = tx;
                    ns = 1;
                end
            end else begin
                samp[ns] = tx;
                ns++;
            end
            if (in_frame && ns == FRAME) begin
                f.ok = 1'b1;
                for (int b = 0; b < 10; b++)
                    for (int j = 1; j < CPB; j++)
                        if (samp[b*CPB+j] !== samp[b*CPB]) f.ok = 1'b0;
                if (samp[0] !== 1'b0 || samp[9*CPB] !== 1'b1) f.ok = 1'b0;
                for (int k = 0; k < 8; k++) f.data[k] = samp[(k+1)*CPB];
                f.start = fstart;
                got_q.push_back(f);
                in_frame = 1'b0;
            end
        end
    end

    initial begin : stim
        int         acc;
        int         s0;
        int         r;
        int         n;
        int         tries;
        int         occ;
        bit         stayed;
        bit         vnow;
        bit         rdy;
        logic [7:0] b;
        logic [7:0] b2b [3];
        logic [7:0] full_b [5];

        bus.data  = '0;
        bus.valid = 1'b0;
        block     = 1'b0;
        rst       = 1'b1;
        repeat (3) tick();
        check("rst_tx", tx, 1);
        check("rst_ready", bus.ready, 1);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        tick();
        check("post_rst_tx", tx, 1);

        // Single byte 0xA5 from idle.
        last_start = -1000;
        bus.data = 8'hA5;
        bus.valid = 1'b1;
        tick();
        bus.valid = 1'b0;
        acc = cyc;
        check("a5_tx_before_fall", tx, 1);
        check("a5_busy_queued", busy, 1);
        tick();
        check("a5_fall", tx, 0);
        exp_add(8'hA5, next_start(acc));
        repeat (FRAME - 1) tick();
        check("a5_busy_last_cycle", busy, 1);
        tick();
        check("a5_busy_fall", busy, 0);
        tick();
        check_frames("a5");

        // Back-to-back writes on consecutive cycles.
        last_start = -1000;
        b2b = '{8'h00, 8'hFF, 8'h55};
        for (int i = 0; i < 3; i++) begin
            check("b2b_ready", bus.ready, 1);
            bus.data = b2b[i];
            bus.valid = 1'b1;
            tick();
            exp_add(b2b[i], next_start(cyc));
        end
        bus.valid = 1'b0;
        check("b2b_ready_after", bus.ready, 1);
        wait_idle("b2b", 400);
        check_frames("b2b");

        // Fill the FIFO while blocked; the fifth byte must wait for a pop.
        last_start = -1000;
        block = 1'b1;
        for (int i = 0; i < 5; i++) full_b[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) begin
            check("full_ready_fill", bus.ready, 1);
            bus.data = full_b[i];
            bus.valid = 1'b1;
            tick();
        end
        bus.data = full_b[4];
        check("full_ready_low", bus.ready, 0);
        check("full_busy_blocked", busy, 1);
        repeat (5) begin
            tick();
            check("full_hold_ready", bus.ready, 0);
            check("full_hold_tx", tx, 1);
        end
        block = 1'b0;
        tick();
        s0 = cyc;
        check("full_fall", tx, 0);
        check("full_ready_after_pop", bus.ready, 1);
        tick();
        bus.valid = 1'b0;
        acc = cyc;
        last_start = s0;
        exp_add(full_b[0], s0);
        for (int i = 1; i < 4; i++) exp_add(full_b[i], next_start(0));
        exp_add(full_b[4], next_start(acc));
        wait_idle("full", 600);
        check_frames("full");

        // block raised mid-frame: the frame finishes, the next one waits.
        last_start = -1000;
        b = 8'($urandom);
        bus.data = 8'h3C;
        bus.valid = 1'b1;
        tick();
        acc = cyc;
        bus.data = b;
        tick();
        bus.valid = 1'b0;
        s0 = acc + 1;
        exp_add(8'h3C, s0);
        repeat (10) tick();
        block = 1'b1;
        while (cyc < s0 + FRAME + 20) tick();
        check("blk_tx_held", tx, 1);
        check("blk_busy_held", busy, 1);
        block = 1'b0;
        r = cyc;
        tick();
        check("blk_fall", tx, 0);
        exp_add(b, r + 1);
        wait_idle("blk", 400);
        check_frames("blk");

        // Reset during data bit 3 with two bytes still queued.
        for (int i = 0; i < 3; i++) begin
            bus.data = (i == 0) ? (8'($urandom) & 8'hF7) : 8'($urandom);
            bus.valid = 1'b1;
            tick();
            if (i == 0) acc = cyc;
        end
        bus.valid = 1'b0;
        s0 = acc + 1;
        while (cyc < s0 + 4 + 3*CPB + 1) tick();
        check("rst_mid_bit3", tx, 0);
        rst = 1'b1;
        tick();
        check("rst_mid_tx", tx, 1);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_ready", bus.ready, 1);
        rst = 1'b0;
        stayed = 1'b1;
        repeat (3 * FRAME) begin
            tick();
            if (tx !== 1'b1 || busy !== 1'b0) stayed = 1'b0;
        end
        check("rst_no_more_frames", stayed, 1);
        check_frames("rst");

        // Push landing on the same edge as a stop-to-start pop at count 1.
        last_start = -1000;
        bus.data = 8'($urandom);
        bus.valid = 1'b1;
        tick();
        acc = cyc;
        exp_add(bus.data, next_start(acc));
        bus.data = 8'($urandom);
        tick();
        exp_add(bus.data, next_start(cyc));
        bus.valid = 1'b0;
        while (cyc < acc + FRAME) tick();
        check("coll_ready_pre", bus.ready, 1);
        check("coll_tx_stop", tx, 1);
        bus.data = 8'($urandom);
        bus.valid = 1'b1;
        tick();
        bus.valid = 1'b0;
        exp_add(bus.data, next_start(cyc));
        check("coll_fall", tx, 0);
        check("coll_ready_post", bus.ready, 1);
        wait_idle("coll", 400);
        check_frames("coll");

        // Random pushes; in_ready is checked against the occupancy model.
        last_start = -1000;
        acc_q.delete();
        n = 0;
        tries = 0;
        while (n < 24 && tries < 4000) begin
            occ = model_occ(cyc);
            rdy = (occ < DEPTH);
            check("rnd_ready", bus.ready, rdy);
            vnow = ($urandom_range(0, 2) == 0);
            b = 8'($urandom);
            bus.valid = vnow;
            bus.data = b;
            tick();
            tries++;
            if (vnow && rdy) begin
                acc_q.push_back(cyc);
                exp_add(b, next_start(cyc));
                n++;
            end
        end
        bus.valid = 1'b0;
        check("rnd_progress", n, 24);
        wait_idle("rnd", 2000);
        check_frames("rnd");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
